rgb_gray_converter: RTL and testbench
=====================================

// Module: rgb_gray_converter
// PURPOSE
//   Frame-walk stage directly upstream of the VGA display process. It fills the gray buffer port that the display reads.
//   On start, it sweeps every pixel address of the IMG_W x IMG_H RGB buffer, converts RGB444 to 4-bit luma, and writes the gray buffer.
//   Fully pipelined at 1 pixel/clock; signals done once the last gray word has been written.
// PARAMETERS
//   IMG_W       120   image width in pixels
//   IMG_H       120   image height in pixels
//   ADDR_W      14    buffer address width (must satisfy IMG_W*IMG_H <= 2**ADDR_W)
//   RD_LATENCY  1     clocks from rd_addr presented to rd_data valid (1..3)
//   THRESH      8     binarisation threshold; only used with GRAY_THRESHOLD_EN
// PORTS
//   clk_50   in   1       system clock; all logic on its rising edge
//   reset    in   1       synchronous, active-high reset
//   start    in   1       1-cycle request to convert one frame
//   busy     out  1       high from the cycle after start is accepted until done
//   done     out  1       1-cycle pulse after the final write
//   rd_en    out  1       RGB buffer read strobe
//   rd_addr  out  ADDR_W  RGB buffer read address
//   rd_data  in   12      RGB444 word: [11:8]=R, [7:4]=G, [3:0]=B
//   wr_en    out  1       gray buffer write strobe
//   wr_addr  out  ADDR_W  gray buffer write address
//   wr_data  out  4       gray value
// BEHAVIOUR
//   Reset: every output is 0. The FSM enters IDLE, clears the read counter, and flushes the pipeline valids.
//   FSM states: IDLE, SWEEP, DRAIN, DONE.
//     IDLE  -> SWEEP when start=1. In the next cycle busy=1, rd_en=1, rd_addr=0.
//     SWEEP: rd_addr increments by 1 each clock. After rd_addr = IMG_W*IMG_H-1 is issued, go to DRAIN with rd_en=0.
//     DRAIN: stay until the pipeline valid shift register is empty.
//     DONE:  done=1 and busy=0 for exactly one cycle, then return to IDLE.
//   Pipeline: rd_en/rd_addr are delayed RD_LATENCY clocks to align with rd_data, then pass through one compute register stage.
//     Gray for address N is written RD_LATENCY+1 clocks after rd_addr=N is issued; wr_addr=N.
//   Arithmetic: sum = 77*R + 150*G + 29*B, computed as a 12-bit unsigned value (maximum 3840, no overflow).
//     gray = sum[11:8], truncated with no rounding; 12'hFFF maps to 4'hF.
//   Throughput: wr_en is high for exactly IMG_W*IMG_H consecutive cycles, with no gaps or duplicates.
//     Total busy cycles = IMG_W*IMG_H + RD_LATENCY + 1.
//   Boundary conditions:
//     start while busy or in DONE: ignored, with no restart and no queueing.
//     start in the same cycle as reset: reset wins.
//     Reset mid-frame: all outputs are 0 in the cycle after reset. Pending writes are discarded, not completed.
//       The next start begins again at address 0.
//     Address counters never wrap past IMG_W*IMG_H-1.
//     wr_data/wr_addr hold their last values when wr_en=0 (don't-care to consumers).
// CONFIGURATION
//   GRAY_THRESHOLD_EN defined:
//     wr_data = (gray >= THRESH) ? 4'hF : 4'h0, using the same latency and the same register stage.
//   GRAY_THRESHOLD_EN undefined:
//     wr_data = gray; THRESH is unused; no comparator is synthesised.
// TESTING
//   T1 Reset: hold reset 3 cycles -> busy=done=rd_en=wr_en=0 and all addresses 0.
//      start pulsed during reset -> no activity afterwards.
//   T2 Uniform rd_data=12'hFFF, RD_LATENCY=1, one start -> 14400 writes, each wr_data=4'hF with wr_addr 0..14399 contiguous.
//      done pulses exactly 14402 cycles after the first busy cycle.
//   T3 Channel weights: R=12'hF00 -> 4'h4; G=12'h0F0 -> 4'h8; B=12'h00F -> 4'h1; 12'h000 -> 4'h0; 12'h888 -> 4'h8.
//   T4 Model buffer returning rd_data = addr[11:0] -> every wr_data matches the reference formula at the same address.
//      Repeat with RD_LATENCY=3; rd_addr -> wr_addr latency = 4.
//   T5 Assert reset when wr_addr=5000 -> no wr_en in the cycle after reset.
//      Subsequent start -> first write is to addr 0; full 14400 writes; done once.
//   T6 start re-pulsed at cycle 100 of busy -> ignored, exactly one done.
//      With GRAY_THRESHOLD_EN and THRESH=8: G=12'h0F0 -> 4'hF, B=12'h00F -> 4'h0.

Source files
------------

// File: rtl/rgb_gray_converter.sv
// Frame-walk stage: sweeps the RGB444 buffer, converts each pixel to 4-bit luma and fills the gray buffer at 1 pixel/clock.
// Optional GRAY_THRESHOLD_EN macro binarises the output against THRESH.
module rgb_gray_converter #(
  parameter int IMG_W      = 120,
  parameter int IMG_H      = 120,
  parameter int ADDR_W     = 14,
  parameter int RD_LATENCY = 1,
  parameter int THRESH     = 8
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  if (NPIX > (2 ** ADDR_W) || RD_LATENCY < 1 || RD_LATENCY > 3 || THRESH < 0 || THRESH > 15) begin : g_param_check
    $error("rgb_gray_converter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_W-1:0]       rd_addr_reg;
  logic [ADDR_W-1:0]       rd_addr_next;

  // Read-side delay line: valid and address travel alongside the buffer latency.
  logic [RD_LATENCY-1:0]   vld_pipe_reg;
  logic [ADDR_W-1:0]       addr_pipe_reg [RD_LATENCY];

  logic                    wr_en_reg;
  logic [ADDR_W-1:0]       wr_addr_reg;
  logic [3:0]              wr_data_reg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_reg   <= IDLE;
      rd_addr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rd_addr_reg <= rd_addr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_addr_reg;
    busy         = 1'b0;
    done         = 1'b0;
    rd_en        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = SWEEP;
          rd_addr_next = '0;
        end
      end
      SWEEP: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        // Hold on the last address rather than wrapping back to zero.
        if (rd_addr_reg == LAST_ADDR) begin
          state_next = DRAIN;
        end else begin
          rd_addr_next = rd_addr_reg + ADDR_W'(1);
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (vld_pipe_reg == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rd_addr = rd_addr_reg;

  // ---------------------------------------------------------------- read latency alignment
  always_ff @(posedge clk_50) begin
    if (reset) begin
      vld_pipe_reg <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        addr_pipe_reg[i] <= '0;
      end
    end else begin
      vld_pipe_reg[0]  <= rd_en;
      addr_pipe_reg[0] <= rd_addr_reg;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_reg[i]  <= vld_pipe_reg[i-1];
        addr_pipe_reg[i] <= addr_pipe_reg[i-1];
      end
    end
  end

  // ---------------------------------------------------------------- luma arithmetic
  // Channel index 0 = B, 1 = G, 2 = R; weights sum to 256 so the top nibble is the luma.
  localparam logic [11:0] WEIGHT [3] = '{12'd29, 12'd150, 12'd77};

  logic [11:0] term [3];
  logic [11:0] sum;
  logic [3:0]  gray;
  logic [3:0]  pix_out;

  for (genvar gi = 0; gi < 3; gi++) begin : g_term
    assign term[gi] = {8'd0, rd_data[gi*4 +: 4]} * WEIGHT[gi];
  end

  assign sum  = term[0] + term[1] + term[2];
  assign gray = 4'(sum >> 8);

`ifdef GRAY_THRESHOLD_EN
  assign pix_out = (gray >= 4'(THRESH)) ? 4'hF : 4'h0;
`else
  assign pix_out = gray;
`endif

  // ---------------------------------------------------------------- compute / write stage
  always_ff @(posedge clk_50) begin
    if (reset) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= vld_pipe_reg[RD_LATENCY-1];
      if (vld_pipe_reg[RD_LATENCY-1]) begin
        wr_addr_reg <= addr_pipe_reg[RD_LATENCY-1];
        wr_data_reg <= pix_out;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_rgb_gray_converter.sv
// Scoreboard bench for rgb_gray_converter: two instances (RD_LATENCY 1 and 3) share reset/start and
// each gets its own buffer model; reads push expectations, a monitor pops them on every write.
module tb_rgb_gray_converter;

  localparam int IMG_W  = 120;
  localparam int IMG_H  = 120;
  localparam int ADDR_W = 14;
  localparam int NPIX   = IMG_W * IMG_H;

`ifdef GRAY_THRESHOLD_EN
  localparam logic [3:0] EXP_R = 4'h0;
  localparam logic [3:0] EXP_G = 4'hF;
  localparam logic [3:0] EXP_B = 4'h0;
  localparam logic [3:0] EXP_K = 4'h0;
  localparam logic [3:0] EXP_M = 4'hF;
`else
  localparam logic [3:0] EXP_R = 4'h4;
  localparam logic [3:0] EXP_G = 4'h8;
  localparam logic [3:0] EXP_B = 4'h1;
  localparam logic [3:0] EXP_K = 4'h0;
  localparam logic [3:0] EXP_M = 4'h8;
`endif

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;
  logic start  = 1'b0;

  logic              busy_w    [2];
  logic              done_w    [2];
  logic              rd_en_w   [2];
  logic              wr_en_w   [2];
  logic [ADDR_W-1:0] rd_addr_w [2];
  logic [ADDR_W-1:0] wr_addr_w [2];
  logic [11:0]       rd_data_w [2];
  logic [3:0]        wr_data_w [2];

  always #10 clk_50 = ~clk_50;

  rgb_gray_converter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RD_LATENCY(1), .THRESH(8)
  ) u_dut_l1 (
    .clk_50(clk_50), .reset(reset), .start(start),
    .busy(busy_w[0]), .done(done_w[0]),
    .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]),
    .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0])
  );

  rgb_gray_converter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RD_LATENCY(3), .THRESH(8)
  ) u_dut_l3 (
    .clk_50(clk_50), .reset(reset), .start(start),
    .busy(busy_w[1]), .done(done_w[1]),
    .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]),
    .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1])
  );

  // ---------------------------------------------------------------- buffer model
  int          mode = 0;          // 0: every pixel = const_pix, 1: pixel = addr[11:0]
  logic [11:0] const_pix = 12'hFFF;

  function automatic logic [11:0] pix(input logic [ADDR_W-1:0] a);
    return (mode == 0) ? const_pix : a[11:0];
  endfunction

  function automatic logic [3:0] ref_gray(input logic [11:0] p);
    int s;
    s = 77 * int'(p[11:8]) + 150 * int'(p[7:4]) + 29 * int'(p[3:0]);
`ifdef GRAY_THRESHOLD_EN
    return ((s / 256) >= 8) ? 4'hF : 4'h0;
`else
    return 4'(s / 256);
`endif
  endfunction

  logic [11:0] mem_l1_reg;
  logic [11:0] mem_l3_reg [3];

  always @(posedge clk_50) begin
    mem_l1_reg    <= pix(rd_addr_w[0]);
    mem_l3_reg[0] <= pix(rd_addr_w[1]);
    mem_l3_reg[1] <= mem_l3_reg[0];
    mem_l3_reg[2] <= mem_l3_reg[1];
  end

  assign rd_data_w[0] = mem_l1_reg;
  assign rd_data_w[1] = mem_l3_reg[2];

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checking
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input int d, input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (RD_LATENCY=%0d) at cycle %0d: got %0d, expected %0d",
                  name, (d == 0) ? 1 : 3, cyc, act, exp);
  endtask

  logic [ADDR_W+3:0] exp_q0 [$];
  logic [ADDR_W+3:0] exp_q1 [$];
  int wr_cnt     [2] = '{0, 0};
  int busy_cnt   [2] = '{0, 0};
  int first_busy [2] = '{-1, -1};
  int first_rd   [2] = '{-1, -1};
  int first_wr   [2] = '{-1, -1};
  int done_total [2] = '{0, 0};
  bit active     [2] = '{1'b0, 1'b0};

  task automatic mon(input int d, input int lat);
    logic [ADDR_W+3:0] e;
    int qsize;
    if (start && !active[d]) begin
      active[d]     = 1'b1;
      wr_cnt[d]     = 0;
      busy_cnt[d]   = 0;
      first_busy[d] = -1;
      first_rd[d]   = -1;
      first_wr[d]   = -1;
    end
    if (rd_en_w[d]) begin
      e = {rd_addr_w[d], ref_gray(pix(rd_addr_w[d]))};
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      if (first_rd[d] < 0) first_rd[d] = cyc;
    end
    if (busy_w[d]) begin
      busy_cnt[d]++;
      if (first_busy[d] < 0) first_busy[d] = cyc;
    end
    if (wr_en_w[d]) begin
      if (first_wr[d] < 0) first_wr[d] = cyc;
      qsize = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (qsize == 0) begin
        chk(d, "unexpected_write", 1, 0);
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        chk(d, "wr_addr_vs_read", int'(wr_addr_w[d]), int'(e[ADDR_W+3:4]));
        chk(d, "wr_data", int'(wr_data_w[d]), int'(e[3:0]));
      end
      chk(d, "wr_addr_contiguous", int'(wr_addr_w[d]), wr_cnt[d]);
      if (mode == 0 && const_pix == 12'hFFF) chk(d, "white_is_F", int'(wr_data_w[d]), 15);
      if (mode == 1) begin
        case (int'(wr_addr_w[d]))
          12'hF00: chk(d, "weight_red",   int'(wr_data_w[d]), int'(EXP_R));
          12'h0F0: chk(d, "weight_green", int'(wr_data_w[d]), int'(EXP_G));
          12'h00F: chk(d, "weight_blue",  int'(wr_data_w[d]), int'(EXP_B));
          12'h000: chk(d, "black",        int'(wr_data_w[d]), int'(EXP_K));
          12'h888: chk(d, "mid_gray",     int'(wr_data_w[d]), int'(EXP_M));
          default: ;
        endcase
      end
      wr_cnt[d]++;
    end
    if (done_w[d]) begin
      done_total[d]++;
      qsize = (d == 0) ? exp_q0.size() : exp_q1.size();
      chk(d, "busy_low_at_done", int'(busy_w[d]), 0);
      chk(d, "frame_write_count", wr_cnt[d], NPIX);
      chk(d, "frame_busy_cycles", busy_cnt[d], NPIX + lat + 1);
      chk(d, "done_delay_from_busy", cyc - first_busy[d], NPIX + lat + 1);
      chk(d, "rd_to_wr_latency", first_wr[d] - first_rd[d], lat + 1);
      chk(d, "scoreboard_empty", qsize, 0);
      active[d] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_50);
      if (reset) begin
        exp_q0.delete();
        exp_q1.delete();
        active[0] = 1'b0;
        active[1] = 1'b0;
      end else begin
        mon(0, 1);
        mon(1, 3);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk(d, {tag, "_busy"},    int'(busy_w[d]),    0);
      chk(d, {tag, "_done"},    int'(done_w[d]),    0);
      chk(d, {tag, "_rd_en"},   int'(rd_en_w[d]),   0);
      chk(d, {tag, "_wr_en"},   int'(wr_en_w[d]),   0);
      chk(d, {tag, "_rd_addr"}, int'(rd_addr_w[d]), 0);
      chk(d, {tag, "_wr_addr"}, int'(wr_addr_w[d]), 0);
      chk(d, {tag, "_wr_data"}, int'(wr_data_w[d]), 0);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk_50); #1 start = 1'b1;
    @(posedge clk_50); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int t1);
    int n;
    n = 0;
    while (!(done_total[0] >= t0 && done_total[1] >= t1) && n < 20000) begin
      @(negedge clk_50);
      n++;
    end
    if (n >= 20000) chk(0, "frame_timeout", n, 0);
  endtask

  initial begin
    int n;
    // Reset held three cycles with a start pulse buried inside it.
    reset = 1'b1;
    @(posedge clk_50); #1 start = 1'b1;
    @(posedge clk_50); #1 start = 1'b0;
    @(posedge clk_50); #1 reset = 1'b0;
    @(negedge clk_50);
    check_idle("reset");
    repeat (20) @(negedge clk_50);
    for (int d = 0; d < 2; d++) begin
      chk(d, "no_activity_after_reset_start", busy_cnt[d] + wr_cnt[d] + done_total[d], 0);
    end
    $display("frame 1: uniform white");

    mode = 0; const_pix = 12'hFFF;
    pulse_start();
    wait_done(1, 1);
    repeat (4) @(negedge clk_50);
    $display("frame 2: address pattern, done=%0d/%0d", done_total[0], done_total[1]);

    mode = 1;
    pulse_start();
    wait_done(2, 2);
    repeat (4) @(negedge clk_50);
    $display("frame 3: pure green with start re-pulsed mid-frame");

    mode = 0; const_pix = 12'h0F0;
    pulse_start();
    repeat (100) @(posedge clk_50);
    #1 start = 1'b1;
    @(posedge clk_50); #1 start = 1'b0;
    wait_done(3, 3);
    repeat (50) @(negedge clk_50);
    for (int d = 0; d < 2; d++) begin
      chk(d, "single_done_despite_restart", done_total[d], 3);
      chk(d, "idle_after_restart_frame", int'(busy_w[d]), 0);
    end
    $display("frame 4: reset mid-frame at wr_addr 5000");

    mode = 1;
    pulse_start();
    n = 0;
    while (!(wr_en_w[0] && wr_addr_w[0] == ADDR_W'(5000)) && n < 8000) begin
      @(negedge clk_50);
      n++;
    end
    if (n >= 8000) chk(0, "reach_addr_5000_timeout", n, 0);
    @(posedge clk_50); #1 reset = 1'b1;
    @(posedge clk_50);
    @(negedge clk_50);
    check_idle("midframe_reset");
    @(posedge clk_50); #1 reset = 1'b0;
    repeat (10) @(negedge clk_50);
    for (int d = 0; d < 2; d++) begin
      chk(d, "aborted_frame_no_done", done_total[d], 3);
      chk(d, "aborted_frame_stays_idle", int'(busy_w[d]), 0);
    end
    $display("frame 5: full frame after mid-frame reset");

    pulse_start();
    wait_done(4, 4);
    repeat (20) @(negedge clk_50);
    for (int d = 0; d < 2; d++) begin
      chk(d, "total_done_pulses", done_total[d], 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
